perips_wb_arbiter: RTL and testbench

Round-robin Wishbone B4 classic arbiter sharing the on-chip peripheral slave port (PLIC, UART, GPIO decode) between up to NUM_MASTERS requesters, typically the core data port and the debug module. It grants one master per bus cycle (held for the whole `cyc` assertion, so locked sequences such as PLIC claim then complete stay atomic), muxes that master's request to the slave, and routes `ack`/`rdata` back. It sits between the masters and the peripheral address decoder.

---
 rtl/perips_wb_arbiter_pkg.sv | 7 +
 rtl/wb_rr_pick.sv | 26 ++
 rtl/perips_wb_arbiter.sv | 112 +++++++++++
 tb/tb_perips_wb_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/perips_wb_arbiter_pkg.sv
// perips_wb_arbiter_pkg: bus widths, timeout read pattern and arbiter state encoding
package perips_wb_arbiter_pkg;
    localparam int WB_AD_WIDTH = 32;
    localparam int WB_DAT_WIDTH = 32;
    localparam logic [31:0] WB_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: first requester searching upward from last+1, wrapping modulo N
module wb_rr_pick #(
    parameter int N = 2,
    localparam int LW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  pick,
    output logic [LW-1:0] idx
);
    logic [LW-1:0] c;
    logic found;
    always_comb begin
        c = last;
        found = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            c = (c == LW'(N - 1)) ? '0 : c + LW'(1);
            if (!found && req[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
        pick = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end
endmodule

// File: rtl/perips_wb_arbiter.sv
// perips_wb_arbiter: round-robin Wishbone B4 classic arbiter; WB_ARB_TIMEOUT_EN adds a stall timeout
module perips_wb_arbiter
    import perips_wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW = WB_AD_WIDTH,
    parameter int DW = WB_DAT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    wbm_arb_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_arb_stb_i,
    input  logic [NUM_MASTERS*AW-1:0] wbm_arb_addr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_arb_wdata_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_arb_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_arb_we_i,
    output logic [NUM_MASTERS-1:0]    arb_wbm_ack_o,
    output logic [DW-1:0]             arb_wbm_rdata_o,
    output logic                      arb_wbs_cyc_o,
    output logic                      arb_wbs_stb_o,
    output logic                      arb_wbs_we_o,
    output logic [AW-1:0]             arb_wbs_addr_o,
    output logic [DW-1:0]             arb_wbs_wdata_o,
    output logic [DW/8-1:0]           arb_wbs_sel_o,
    input  logic                      wbs_arb_ack_i,
    input  logic [DW-1:0]             wbs_arb_rdata_i,
    output logic [NUM_MASTERS-1:0]    arb_grant_o,
    output logic                      arb_timeout_o
);
    localparam int LW = $clog2(NUM_MASTERS);
    arb_state_e state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
    logic [LW-1:0] last_q, last_d, pick_idx;
    logic busy, gcyc, to;

    wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req (wbm_arb_cyc_i),
        .last(last_q),
        .pick(pick),
        .idx (pick_idx)
    );

    assign busy = state_q == BUSY;
    assign gcyc = busy & wbm_arb_cyc_i[last_q];
    assign arb_grant_o = grant_q;

    // last_q doubles as the granted index while BUSY
    always_comb begin
        arb_wbs_cyc_o = gcyc;
        arb_wbs_stb_o = busy & wbm_arb_stb_i[last_q] & ~to;
        arb_wbs_we_o = busy & wbm_arb_we_i[last_q];
        arb_wbs_addr_o = busy ? wbm_arb_addr_i[last_q*AW +: AW] : '0;
        arb_wbs_wdata_o = busy ? wbm_arb_wdata_i[last_q*DW +: DW] : '0;
        arb_wbs_sel_o = busy ? wbm_arb_sel_i[last_q*(DW/8) +: DW/8] : '0;
        arb_wbm_ack_o = '0;
        arb_wbm_ack_o[last_q] = gcyc & (wbs_arb_ack_i | to);
        arb_wbm_rdata_o = to ? DW'(WB_ARB_TIMEOUT_DATA) : wbs_arb_rdata_i;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d = last_q;
        if (!busy) begin
            if (|wbm_arb_cyc_i) begin
                state_d = BUSY;
                grant_d = pick;
                last_d = pick_idx;
            end
        end else if (!wbm_arb_cyc_i[last_q]) begin
            state_d = IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q <= LW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic timeout_q, timeout_d, stall;
    always_comb begin
        stall = gcyc & wbm_arb_stb_i[last_q] & ~wbs_arb_ack_i;
        to = stall && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
        cnt_d = (stall && !to) ? cnt_q + 8'd1 : 8'd0;
        timeout_d = timeout_q | to;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign arb_timeout_o = timeout_q;
`else
    assign to = 1'b0;
    assign arb_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_perips_wb_arbiter.sv
// tb_perips_wb_arbiter: directed and random checks against an integer-level arbitration model
module tb_perips_wb_arbiter;
    localparam int N = 2, AW = 32, DW = 32, TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TOEN = 1'b1;
`else
    localparam bit TOEN = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] cyc_i = '0, stb_i = '0, we_i = '0, ack_o, grant_o;
    logic [N*AW-1:0] addr_i = '0;
    logic [N*DW-1:0] wdata_i = '0;
    logic [N*DW/8-1:0] sel_i = '0;
    logic [DW-1:0] rdata_o, rdata_i = '0, wbs_wdata;
    logic [AW-1:0] wbs_addr;
    logic [DW/8-1:0] wbs_sel;
    logic wbs_cyc, wbs_stb, wbs_we, ack_i = 1'b0, timeout_o;
    int n_chk = 0, n_fail = 0;
    int owner = -1, last = N - 1, scnt = 0;
    bit tflag = 1'b0;
    logic [N-1:0] g_obs, a_obs;
    logic [DW-1:0] r_obs;

    always #5 clk = ~clk;

    perips_wb_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .wbm_arb_cyc_i(cyc_i), .wbm_arb_stb_i(stb_i), .wbm_arb_addr_i(addr_i),
        .wbm_arb_wdata_i(wdata_i), .wbm_arb_sel_i(sel_i), .wbm_arb_we_i(we_i),
        .arb_wbm_ack_o(ack_o), .arb_wbm_rdata_o(rdata_o),
        .arb_wbs_cyc_o(wbs_cyc), .arb_wbs_stb_o(wbs_stb), .arb_wbs_we_o(wbs_we),
        .arb_wbs_addr_o(wbs_addr), .arb_wbs_wdata_o(wbs_wdata), .arb_wbs_sel_o(wbs_sel),
        .wbs_arb_ack_i(ack_i), .wbs_arb_rdata_i(rdata_i),
        .arb_grant_o(grant_o), .arb_timeout_o(timeout_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        owner = -1;
        last = N - 1;
        scnt = 0;
        tflag = 1'b0;
    endtask

    // one bus cycle: drive, check at negedge against the model, advance the model at posedge
    task automatic step(input logic [N-1:0] c, input logic [N-1:0] s, input logic [N-1:0] w,
                        input logic a, input logic [DW-1:0] rd);
        int o, oo;
        logic gc, st, t;
        cyc_i = c; stb_i = s; we_i = w; ack_i = a; rdata_i = rd;
        addr_i = {$urandom, $urandom};
        wdata_i = {$urandom, $urandom};
        sel_i = 8'($urandom);
        @(negedge clk);
        o = owner;
        oo = (o < 0) ? 0 : o;
        gc = (o >= 0) ? c[oo] : 1'b0;
        st = gc && s[oo] && !a;
        t = TOEN && st && (scnt == TO - 1);
        g_obs = grant_o; a_obs = ack_o; r_obs = rdata_o;
        chk("grant", grant_o, (o >= 0) ? 64'(1) << oo : 64'(0));
        chk("wbs_cyc", wbs_cyc, gc);
        chk("wbs_stb", wbs_stb, (o >= 0) && s[oo] && !t);
        chk("wbs_we", wbs_we, (o >= 0) && w[oo]);
        chk("wbs_addr", wbs_addr, (o >= 0) ? addr_i[oo*AW +: AW] : '0);
        chk("wbs_wdata", wbs_wdata, (o >= 0) ? wdata_i[oo*DW +: DW] : '0);
        chk("wbs_sel", wbs_sel, (o >= 0) ? sel_i[oo*(DW/8) +: DW/8] : '0);
        chk("ack", ack_o, (gc && (a || t)) ? 64'(1) << oo : 64'(0));
        chk("rdata", rdata_o, t ? 32'hDEADBEEF : rd);
        chk("timeout", timeout_o, tflag);
        @(posedge clk);
        tflag |= t;
        scnt = (st && !t) ? scnt + 1 : 0;
        if (owner < 0) begin
            for (int i = 1; i <= N; i++)
                if (c[(last + i) % N]) begin
                    owner = (last + i) % N;
                    last = owner;
                    break;
                end
        end else if (!c[owner]) owner = -1;
        #1;
    endtask

    task automatic dorst();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_wbs_cyc", wbs_cyc, 1'b0);
        chk("rst_grant", grant_o, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();
    endtask

    initial begin
        int q[$];
        logic [N-1:0] prev, rc;
        logic [5:0] tv;
        logic [N-1:0] pat [12];
        int exp_o [4];
        pat = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b01};
        exp_o = '{1, 2, 1, 2};
        #1;
        chk("reset_grant", grant_o, '0);
        chk("reset_wbs_cyc", wbs_cyc, 1'b0);
        chk("reset_ack", ack_o, '0);
        chk("reset_timeout", timeout_o, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mreset();

        step(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        step(2'b01, 2'b01, 2'b00, 1'b1, 32'h2);
        chk("t1_ack", a_obs, 2'b01);
        chk("t1_rdata", r_obs, 32'h2);
        step(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

        dorst();
        step(2'b11, 2'b11, 2'b00, 1'b0, $urandom);
        step(2'b11, 2'b11, 2'b00, 1'b1, $urandom);
        chk("t2_first", g_obs, 2'b01);
        step(2'b10, 2'b10, 2'b00, 1'b0, $urandom);
        step(2'b10, 2'b10, 2'b00, 1'b0, $urandom);
        chk("t2_dead", g_obs, 2'b00);
        step(2'b10, 2'b10, 2'b00, 1'b1, $urandom);
        chk("t2_second", g_obs, 2'b10);
        step(2'b00, 2'b00, 2'b00, 1'b0, $urandom);

        step(2'b01, 2'b01, 2'b00, 1'b0, $urandom);
        step(2'b11, 2'b11, 2'b00, 1'b1, 32'h5);
        chk("t3_claim_ack", a_obs, 2'b01);
        step(2'b11, 2'b11, 2'b01, 1'b1, $urandom);
        chk("t3_complete_ack", a_obs, 2'b01);
        step(2'b10, 2'b10, 2'b00, 1'b0, $urandom);
        chk("t3_held", g_obs, 2'b01);
        step(2'b10, 2'b10, 2'b00, 1'b0, $urandom);
        step(2'b10, 2'b10, 2'b00, 1'b1, $urandom);
        chk("t3_m1_ack", a_obs, 2'b10);
        step(2'b00, 2'b00, 2'b00, 1'b0, $urandom);

        dorst();
        prev = '0;
        for (int k = 0; k < 12; k++) begin
            step(pat[k], pat[k], 2'b00, 1'b1, $urandom);
            if (g_obs != '0 && prev == '0) q.push_back(int'(g_obs));
            prev = g_obs;
        end
        step(2'b00, 2'b00, 2'b00, 1'b0, $urandom);
        chk("rr_count", q.size(), 4);
        for (int i = 0; i < 4 && i < q.size(); i++) chk("rr_order", q[i], exp_o[i]);

`ifdef WB_ARB_TIMEOUT_EN
        dorst();
        for (int k = 0; k < 6; k++) begin
            step(2'b01, 2'b01, 2'b00, 1'b0, $urandom);
            tv[k] = a_obs[0];
            if (k == 4) chk("to_rdata", r_obs, 32'hDEADBEEF);
        end
        chk("to_ack_pattern", tv, 6'b010000);
        step(2'b00, 2'b00, 2'b00, 1'b0, $urandom);
        chk("to_sticky", timeout_o, 1'b1);
`endif

        step(2'b01, 2'b01, 2'b00, 1'b0, $urandom);
        step(2'b01, 2'b01, 2'b00, 1'b0, $urandom);
        chk("midrst_busy", g_obs, 2'b01);
        dorst();

        rc = '0;
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < N; m++)
                rc[m] = rc[m] ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            step(rc, rc & N'($urandom), N'($urandom), 1'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
